// File: rtl/uart_fifo_core.sv
// uart_fifo_core: programmable-baud UART with valid/ready TX/RX circular FIFOs and sticky error flags.
// Optional parity generation/checking is compiled in when UART_PARITY_EN is defined.

module uart_fifo_buf #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk_100MHz,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int PW = AW + 1;

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr, rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + PW'(1);
            if (pop  && !empty) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module uart_fifo_core #(
    parameter int DBITS        = 8,
    parameter int OSR          = 16,
    parameter int DIV_BITS     = 16,
    parameter int TX_DEPTH_EXP = 4,
    parameter int RX_DEPTH_EXP = 4
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    input  logic [DIV_BITS-1:0]     baud_div,
    input  logic                    two_stop,
    input  logic [1:0]              parity_mode,
    input  logic [DBITS-1:0]        tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [DBITS-1:0]        rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [TX_DEPTH_EXP:0]   tx_level,
    output logic [RX_DEPTH_EXP:0]   rx_level,
    output logic                    tx_busy,
    output logic                    frame_err,
    output logic                    parity_err,
    output logic                    overrun,
    input  logic                    clear_err,
    input  logic                    rx,
    output logic                    tx
);
    localparam int               OW   = $clog2(OSR);
    localparam logic [3:0]       DB   = 4'(DBITS);
    localparam logic [OW-1:0]    OS_LAST = OW'(OSR - 1);
    localparam logic [OW-1:0]    OS_MID  = OW'(OSR / 2 - 1);
    localparam logic [DIV_BITS-1:0] ONE = DIV_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Baud tick: the period limit is latched at each wrap, the first period after reset uses the live value.
    logic [DIV_BITS-1:0] tick_cnt, tick_lim, live_last, cur_last;
    logic                tick_lim_ok, tick;

    assign live_last = (baud_div < DIV_BITS'(2)) ? ONE : baud_div - ONE;
    assign cur_last  = tick_lim_ok ? tick_lim : live_last;
    assign tick      = (tick_cnt >= cur_last);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt    <= '0;
            tick_lim    <= '0;
            tick_lim_ok <= 1'b0;
        end else if (tick) begin
            tick_cnt    <= '0;
            tick_lim    <= live_last;
            tick_lim_ok <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + ONE;
        end
    end

`ifdef UART_PARITY_EN
    logic par_en_cfg, par_odd_cfg;
    assign par_en_cfg  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign par_odd_cfg = (parity_mode == 2'b01);
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    logic             tx_pop, tx_empty, tx_full;
    logic [DBITS-1:0] tx_head, tx_shift;
    state_t           tx_state;
    logic [OW-1:0]    tx_os;
    logic [3:0]       tx_bit;
    logic             tx_two, tx_stop2, tx_frame_end;
`ifdef UART_PARITY_EN
    logic             tx_par_en, tx_par;
`endif

    uart_fifo_buf #(.W(DBITS), .AW(TX_DEPTH_EXP)) u_tx_fifo (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .push       (tx_valid),
        .wdata      (tx_data),
        .pop        (tx_pop),
        .rdata      (tx_head),
        .full       (tx_full),
        .empty      (tx_empty),
        .level      (tx_level)
    );

    assign tx_ready     = !tx_full;
    assign tx_busy      = (tx_state != S_IDLE) || !tx_empty;
    assign tx_frame_end = tick && (tx_os == OS_LAST) && (tx_state == S_STOP) && (!tx_two || tx_stop2);
    // Reloading straight from the last stop bit gives back-to-back frames with no idle gap.
    assign tx_pop       = !tx_empty && ((tick && tx_state == S_IDLE) || tx_frame_end);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_two   <= 1'b0;
            tx_stop2 <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_en <= 1'b0;
            tx_par    <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx       <= 1'b0;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_shift <= tx_head;
            tx_two   <= two_stop;
            tx_stop2 <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_en <= par_en_cfg;
            tx_par    <= par_odd_cfg ? ~^tx_head : ^tx_head;
`endif
        end else if (tick && tx_state != S_IDLE) begin
            tx_os <= tx_os + OW'(1);
            if (tx_os == OS_LAST) begin
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= 4'd1;
                    end
                    S_DATA: begin
                        if (tx_bit == DB) begin
`ifdef UART_PARITY_EN
                            if (tx_par_en) begin
                                tx_state <= S_PARITY;
                                tx       <= tx_par;
                            end else
`endif
                            begin
                                tx_state <= S_STOP;
                                tx       <= 1'b1;
                            end
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 4'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        tx_state <= S_STOP;
                        tx       <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        if (tx_two && !tx_stop2) tx_stop2 <= 1'b1;
                        else                     tx_state <= S_IDLE;
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    logic             rx_meta, rx_s;
    logic             rx_push, rx_full, rx_empty, rx_sample, rx_stop_sample, rx_par_fail;
    logic             frame_set, ovr_set;
    logic [DBITS-1:0] rx_head, rx_shift;
    state_t           rx_state;
    logic [OW-1:0]    rx_os;
    logic [3:0]       rx_bit;
`ifdef UART_PARITY_EN
    logic             rx_par_en, rx_par_odd, rx_par_acc, rx_par_bad, par_set;
`endif

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_fifo_buf #(.W(DBITS), .AW(RX_DEPTH_EXP)) u_rx_fifo (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .push       (rx_push),
        .wdata      (rx_shift),
        .pop        (rx_ready),
        .rdata      (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .level      (rx_level)
    );

    assign rx_valid       = !rx_empty;
    assign rx_data        = rx_valid ? rx_head : '0;
    assign rx_sample      = tick && (rx_os == OS_LAST);
    assign rx_stop_sample = rx_sample && (rx_state == S_STOP);
`ifdef UART_PARITY_EN
    assign rx_par_fail    = rx_par_en && rx_par_bad;
    assign par_set        = rx_stop_sample && rx_s && rx_par_fail;
`else
    assign rx_par_fail    = 1'b0;
`endif
    // A low stop bit takes precedence over a parity mismatch; either way the byte is discarded.
    assign frame_set      = rx_stop_sample && !rx_s;
    assign rx_push        = rx_stop_sample && rx_s && !rx_par_fail;
    assign ovr_set        = rx_push && rx_full;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= S_IDLE;
            rx_os    <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_acc <= 1'b0;
            rx_par_bad <= 1'b0;
`endif
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= S_START;
                        rx_os    <= '0;
                        rx_bit   <= '0;
`ifdef UART_PARITY_EN
                        rx_par_en  <= par_en_cfg;
                        rx_par_odd <= par_odd_cfg;
                        rx_par_acc <= 1'b0;
                        rx_par_bad <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_os == OS_MID) begin
                            rx_os    <= '0;
                            rx_state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            rx_os <= rx_os + OW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        rx_os <= rx_os + OW'(1);
                        if (rx_os == OS_LAST) begin
                            rx_shift <= {rx_s, rx_shift[DBITS-1:1]};
                            rx_bit   <= rx_bit + 4'd1;
`ifdef UART_PARITY_EN
                            rx_par_acc <= rx_par_acc ^ rx_s;
                            if (rx_bit == DB - 4'd1) rx_state <= rx_par_en ? S_PARITY : S_STOP;
`else
                            if (rx_bit == DB - 4'd1) rx_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        rx_os <= rx_os + OW'(1);
                        if (rx_os == OS_LAST) begin
                            rx_par_bad <= ((rx_par_acc ^ rx_s) != rx_par_odd);
                            rx_state   <= S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        rx_os <= rx_os + OW'(1);
                        if (rx_os == OS_LAST) rx_state <= S_IDLE;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as clear_err wins.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)      frame_err <= 1'b1;
            else if (clear_err) frame_err <= 1'b0;
            if (ovr_set)        overrun   <= 1'b1;
            else if (clear_err) overrun   <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n)       parity_err <= 1'b0;
        else if (par_set)   parity_err <= 1'b1;
        else if (clear_err) parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: expected bytes are queued at stimulus time and checked by TX/RX monitors.

module tb_uart_fifo_core;
    localparam int BIT_CLKS = 64;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b1;
    logic [15:0] baud_div   = 16'd4;
    logic        two_stop   = 1'b0;
    logic [1:0]  parity_mode = 2'b00;
    logic [7:0]  tx_data    = 8'h00;
    logic        tx_valid   = 1'b0;
    logic        rx_ready   = 1'b1;
    logic        clear_err  = 1'b0;
    logic        drv_rx     = 1'b1;
    logic        loop_en    = 1'b0;
    logic        tx_mon_en  = 1'b1;

    logic        tx_ready, rx_valid, tx_busy, frame_err, parity_err, overrun, tx;
    logic [7:0]  rx_data;
    logic [4:0]  tx_level, rx_level;
    logic        rx_line;

    logic [7:0]  tx_exp [$];
    logic [7:0]  rx_exp [$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [7:0]  tx_got;
    logic        tx_frame_ok;
    logic [7:0]  burst_bytes [16] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33, 8'hCC,
                                      8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hFE};

    assign rx_line = loop_en ? tx : drv_rx;

    uart_fifo_core dut (
        .clk_100MHz  (clk_100MHz),
        .reset_n     (reset_n),
        .baud_div    (baud_div),
        .two_stop    (two_stop),
        .parity_mode (parity_mode),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .tx_busy     (tx_busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .clear_err   (clear_err),
        .rx          (rx_line),
        .tx          (tx)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit expect_tx, input bit expect_rx);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(posedge clk_100MHz); #1;
            n++;
        end
        if (expect_tx) tx_exp.push_back(data);
        if (expect_rx) rx_exp.push_back(data);
        tx_data  = data;
        tx_valid = 1'b1;
        @(posedge clk_100MHz); #1;
        tx_valid = 1'b0;
    endtask

    task automatic sendRxFrame(input logic [7:0] data, input bit with_par, input bit par_bit, input bit bad_stop);
        drv_rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk_100MHz);
        for (int i = 0; i < 8; i++) begin
            drv_rx = data[i];
            repeat (BIT_CLKS) @(posedge clk_100MHz);
        end
        if (with_par) begin
            drv_rx = par_bit;
            repeat (BIT_CLKS) @(posedge clk_100MHz);
        end
        drv_rx = !bad_stop;
        repeat (48) @(posedge clk_100MHz);
        drv_rx = 1'b1;
        repeat (80) @(posedge clk_100MHz);
    endtask

    task automatic waitDrain(input string name, input int max_cycles);
        int n = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < max_cycles) begin
            @(posedge clk_100MHz);
            n++;
        end
        #1;
        checkOutput({name, "_pending"}, tx_exp.size() + rx_exp.size(), 0);
    endtask

    task automatic pulseClear();
        @(posedge clk_100MHz); #1;
        clear_err = 1'b1;
        @(posedge clk_100MHz); #1;
        clear_err = 1'b0;
    endtask

    // RX scoreboard: every popped byte must match the oldest queued expectation.
    always @(negedge clk_100MHz) begin
        if (reset_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (rx_exp.size() == 0) checkOutput("rx_unexpected", {24'h0, rx_data}, 32'h100);
            else                    checkOutput("rx_data", {24'h0, rx_data}, {24'h0, rx_exp.pop_front()});
        end
    end

    // TX monitor: decodes each frame at mid-bit from the falling start edge.
    always begin
        @(negedge tx);
        if (tx_mon_en && reset_n) begin
            repeat (BIT_CLKS / 2) @(negedge clk_100MHz);
            tx_frame_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(negedge clk_100MHz);
                tx_got[i] = tx;
            end
            repeat (BIT_CLKS) @(negedge clk_100MHz);
            tx_frame_ok = tx_frame_ok && (tx === 1'b1);
            checkOutput("tx_framing", {31'h0, tx_frame_ok}, 32'h1);
            if (tx_exp.size() == 0) checkOutput("tx_unexpected", {24'h0, tx_got}, 32'h100);
            else                    checkOutput("tx_byte", {24'h0, tx_got}, {24'h0, tx_exp.pop_front()});
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        #2 reset_n = 1'b0;
        #20;
        checkOutput("reset_tx", {31'h0, tx}, 32'h1);
        checkOutput("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
        checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("reset_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("reset_tx_level", {27'h0, tx_level}, 32'h0);
        checkOutput("reset_rx_level", {27'h0, rx_level}, 32'h0);
        checkOutput("reset_tx_busy", {31'h0, tx_busy}, 32'h0);
        checkOutput("reset_flags", {29'h0, frame_err, parity_err, overrun}, 32'h0);
        @(negedge clk_100MHz) reset_n = 1'b1;

        $display("[TB] single byte loopback");
        loop_en = 1'b1;
        applyStimulus(8'hA5, 1'b1, 1'b1);
        waitDrain("single", 1500);
        checkOutput("single_flags", {29'h0, frame_err, parity_err, overrun}, 32'h0);
        checkOutput("single_rx_level", {27'h0, rx_level}, 32'h0);

        $display("[TB] tx full and backpressure");
        repeat (100) @(posedge clk_100MHz);
        loop_en  = 1'b0;
        reset_n  = 1'b0;
        baud_div = 16'd1000;
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz) reset_n = 1'b1;
        @(posedge clk_100MHz); #1;
        for (int i = 0; i < 16; i++) begin
            tx_exp.push_back(burst_bytes[i]);
            tx_data  = burst_bytes[i];
            tx_valid = 1'b1;
            @(posedge clk_100MHz); #1;
        end
        tx_valid = 1'b0;
        checkOutput("full_tx_level", {27'h0, tx_level}, 32'd16);
        checkOutput("full_tx_ready", {31'h0, tx_ready}, 32'h0);
        checkOutput("full_tx_busy", {31'h0, tx_busy}, 32'h1);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        @(posedge clk_100MHz); #1;
        tx_valid = 1'b0;
        checkOutput("full_push_ignored", {27'h0, tx_level}, 32'd16);
        baud_div = 16'd4;
        waitDrain("burst", 12000);
        repeat (100) @(posedge clk_100MHz); #1;
        checkOutput("burst_tx_level", {27'h0, tx_level}, 32'h0);

        $display("[TB] framing error and start glitch");
        sendRxFrame(8'h3C, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("frame_err_set", {31'h0, frame_err}, 32'h1);
        checkOutput("frame_rx_level", {27'h0, rx_level}, 32'h0);
        pulseClear();
        checkOutput("frame_err_clear", {31'h0, frame_err}, 32'h0);
        drv_rx = 1'b0;
        repeat (16) @(posedge clk_100MHz);
        drv_rx = 1'b1;
        repeat (700) @(posedge clk_100MHz); #1;
        checkOutput("glitch_rx_level", {27'h0, rx_level}, 32'h0);
        checkOutput("glitch_frame_err", {31'h0, frame_err}, 32'h0);

        $display("[TB] rx overrun");
        rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_exp.push_back(8'(8'h11 * i));
            sendRxFrame(8'(8'h11 * i), 1'b0, 1'b0, 1'b0);
        end
        #1;
        checkOutput("ovr_rx_level", {27'h0, rx_level}, 32'd16);
        checkOutput("ovr_flag", {31'h0, overrun}, 32'h1);
        checkOutput("ovr_rx_valid", {31'h0, rx_valid}, 32'h1);
        pulseClear();
        checkOutput("ovr_clear", {31'h0, overrun}, 32'h0);
        rx_ready = 1'b1;
        waitDrain("overrun", 200);
        checkOutput("ovr_drained_level", {27'h0, rx_level}, 32'h0);

`ifdef UART_PARITY_EN
        $display("[TB] parity");
        parity_mode = 2'b10;
        sendRxFrame(8'h07, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("parity_err_set", {31'h0, parity_err}, 32'h1);
        checkOutput("parity_rx_level", {27'h0, rx_level}, 32'h0);
        pulseClear();
        rx_exp.push_back(8'h07);
        sendRxFrame(8'h07, 1'b1, 1'b1, 1'b0);
        waitDrain("parity_good", 200);
        checkOutput("parity_err_clear", {31'h0, parity_err}, 32'h0);
        parity_mode = 2'b00;
`endif

        $display("[TB] reset mid-frame");
        loop_en   = 1'b1;
        tx_mon_en = 1'b0;
        applyStimulus(8'hF0, 1'b0, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk_100MHz);
            n++;
        end
        checkOutput("midframe_start_seen", {31'h0, tx}, 32'h0);
        repeat (BIT_CLKS * 4 + BIT_CLKS / 2 - 1) @(negedge clk_100MHz);
        checkOutput("midframe_bit3_low", {31'h0, tx}, 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("midframe_tx_high", {31'h0, tx}, 32'h1);
        checkOutput("midframe_tx_level", {27'h0, tx_level}, 32'h0);
        checkOutput("midframe_rx_level", {27'h0, rx_level}, 32'h0);
        checkOutput("midframe_tx_busy", {31'h0, tx_busy}, 32'h0);
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz) reset_n = 1'b1;
        tx_mon_en = 1'b1;
        applyStimulus(8'hC3, 1'b1, 1'b1);
        waitDrain("post_reset", 1500);
        checkOutput("post_reset_flags", {29'h0, frame_err, parity_err, overrun}, 32'h0);

        repeat (100) @(posedge clk_100MHz);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised UART core with a runtime-programmable baud divisor, configurable frame format, and independent TX/RX circular FIFOs. Both FIFOs use valid/ready streaming handshakes. Error flags cover framing, parity and overrun. It sits between the badge's ECP5 logic and the USB-serial/debug header. It supersedes the fixed-batch UART top: callers stream bytes one at a time and see backpressure, instead of loading a fixed 4-byte batch.

## Interface
Parameters:
- DBITS, 8, data bits per frame (5–9)
- OSR, 16, oversampling ticks per bit (power of two, ≥8)
- DIV_BITS, 16, width of the baud divisor input
- TX_DEPTH_EXP, 4, log2 of TX FIFO depth (depth 16)
- RX_DEPTH_EXP, 4, log2 of RX FIFO depth (depth 16)

Ports:
- clk_100MHz  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- baud_div  in  DIV_BITS  clocks per oversample tick; values 0 and 1 are treated as 2
- two_stop  in  1  1 = two stop bits
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 none
- tx_data  in  DBITS  byte to send
- tx_valid  in  1  push request
- tx_ready  out  1  TX FIFO not full
- rx_data  out  DBITS  head of RX FIFO
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop request
- tx_level  out  TX_DEPTH_EXP+1  TX FIFO occupancy
- rx_level  out  RX_DEPTH_EXP+1  RX FIFO occupancy
- tx_busy  out  1  shifter not IDLE or TX FIFO non-empty
- frame_err, parity_err, overrun  out  1 each  sticky error flags
- clear_err  in  1  synchronous clear of all three sticky flags
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output

## Operation
- Tick generator:
  - Counter runs 0..D−1, where D = max(baud_div, 2).
  - Emits a one-cycle tick when the counter equals D−1.
  - A change to baud_div takes effect on the next wrap.
- FIFOs:
  - Storage is a circular buffer with wrapping pointers of width DEPTH_EXP+1.
  - Full means the pointer MSBs differ and the remaining bits are equal.
- Handshakes:
  - Push occurs when tx_valid & tx_ready.
  - Pop occurs when rx_valid & rx_ready.
  - Push to a full FIFO and pop from an empty FIFO are no-ops.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged.
- TX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: if the FIFO is non-empty, pop it into the shift register and go to START.
  - Each bit lasts OSR ticks. Data is sent LSB first.
  - PARITY is skipped when parity is none.
  - STOP lasts 1 or 2 bits, per two_stop.
  - Back-to-back frames have no idle gap.
- RX front end: rx passes through a 2-FF synchronizer. The FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronized low starts START.
  - START: at tick OSR/2−1, if the line is still low, sampling is aligned to mid-bit. Otherwise it is a glitch and the FSM returns to IDLE.
  - DATA and later states sample every OSR ticks at mid-bit.
  - Only the first stop bit is checked.
- Frame outcomes:
  - A low stop bit sets frame_err. The byte is discarded.
  - A parity mismatch sets parity_err. The byte is discarded.
  - A good frame pushes into the RX FIFO. If the FIFO is full, the byte is dropped and overrun is set.
- Sticky flags hold until clear_err. If clear_err and a new error occur in the same cycle, the flag is set (the set wins).
- Configuration inputs (two_stop, parity_mode) are sampled at frame start. They must be held stable while tx_busy is high or RX is active.

## Timing
- Reset values:
  - tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0.
  - Levels = 0, tx_busy = 0, all error flags = 0.
  - FSMs in IDLE, tick counter = 0.
- Reset asserted mid-frame aborts immediately. tx returns to 1 asynchronously and both FIFOs are emptied.
- TX latency: a push into an empty FIFO with an idle FSM drives tx low (start bit) on the clock edge after the next tick.
- RX latency: rx_valid rises 1 clock after the first stop-bit sample. rx_data is registered and valid in the same cycle as rx_valid.
- Level outputs and tx_ready/rx_valid update on the clock edge that follows a handshake.
- Bit period = OSR·D clocks. At D = 54 and OSR = 16, the bit period is 864 clocks (≈115 740 baud at 100 MHz).

## Configuration
- UART_PARITY_EN:
  - Defined: parity generation and checking exist as described.
  - Not defined: the PARITY states are removed, parity_mode is ignored (frames are always sent without parity), and parity_err is tied to 0.

## Test plan
- **Single byte, TX and RX:** baud_div=4, OSR=16, push 0xA5, tx looped to rx → tx shows start, bits 1,0,1,0,0,1,0,1, stop (64 clocks each); rx_valid rises with rx_data=0xA5, and no flags are set.
- **TX full and backpressure:** push 17 bytes with the shifter stalled by reset-then-burst → tx_ready=0 after 16 bytes are accepted with tx_level=16; the 17th push is ignored; all 16 bytes appear on tx in order.
- **RX overrun:** send 17 frames with rx_ready held at 0 → rx_level=16, overrun=1, and the 17th byte is absent; clear_err drops overrun to 0.
- **Framing error:** frame 0x3C with the stop bit forced low → frame_err=1 and rx_level unchanged. A 0.25-bit start glitch causes no reception.
- **Parity** (UART_PARITY_EN): even parity, send 0x07 with parity bit 0 → parity_err=1. The same frame with parity bit 1 → byte accepted.
- **Reset mid-frame:** assert reset_n=0 during DATA bit 3 → tx=1 immediately, levels=0, and a clean frame is sent after release.
